eth_rx_frame: RTL

//  Downstream of the RMII byte receiver: consumes its byte stream (d/dv) and end-of-RX

---
 rtl/eth_rx_frame_pkg.sv | 31 +++
 rtl/eth_crc32.sv | 35 +++
 rtl/eth_rx_frame.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_pkg.sv
// Shared Ethernet receive definitions: CRC-32 constants, frame length limits,
// receive FSM encoding and the byte-wide reflected CRC-32 update.
package eth_rx_frame_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hedb88320;
    localparam logic [31:0] CRC_INIT    = 32'hffffffff;
    localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;
    localparam logic [47:0] BCAST_MAC   = 48'hffff_ffff_ffff;

    localparam int ETH_MIN_LEN = 64;
    localparam int ETH_MAX_LEN = 1522;
    localparam int CNT_W       = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } rx_state_e;

    // LSB-first update, one byte per call
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] r;
        r = crc_in ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Registered CRC-32 accumulator; init restarts from all-ones, and init with en
// folds the first byte into a fresh CRC in the same cycle.
module eth_crc32
    import eth_rx_frame_pkg::*;
(
    input  logic        c,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (en) begin
            crc_d = crc32_byte(init ? CRC_INIT : crc_q, d);
        end else if (init) begin
            crc_d = CRC_INIT;
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_rx_frame.sv
// Receive frame checker: CRC, length and destination checks with FCS stripped
// from the forwarded byte stream by a 4-byte delay line.
module eth_rx_frame
    import eth_rx_frame_pkg::*;
#(
    parameter logic [47:0] MAC     = 48'h01_02_03_04_05_06,
    parameter int          MIN_LEN = ETH_MIN_LEN,
    parameter int          MAX_LEN = ETH_MAX_LEN
) (
    input  logic             c,
    input  logic             rst,
    input  logic [7:0]       d,
    input  logic             dv,
    input  logic             erx,
    output logic [7:0]       od,
    output logic             odv,
    output logic             osof,
    output logic             oeof,
    output logic             ogood,
    output logic             ocrc_err,
    output logic             olen_err,
    output logic             omac_hit,
    output logic [CNT_W-1:0] olen
);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fill_q, fill_d;
    logic [3:0][7:0]  dl_q, dl_d;
    logic             mac_ok_q, mac_ok_d;
    logic             bc_ok_q, bc_ok_d;

    logic [7:0]       od_q, od_d;
    logic             odv_q, odv_d;
    logic             osof_q, osof_d;
    logic             oeof_q, oeof_d;
    logic             ogood_q, ogood_d;
    logic             ocrc_err_q, ocrc_err_d;
    logic             olen_err_q, olen_err_d;
    logic             omac_hit_q, omac_hit_d;
    logic [CNT_W-1:0] olen_q, olen_d;

    logic [31:0]      crc;
    logic             accept;
    logic [47:0]      mac_sh;
    logic             crc_bad, len_bad;

    assign accept  = dv && (state_q != ST_FIN);
    assign mac_sh  = MAC << {cnt_q[2:0], 3'b000};
    assign crc_bad = (crc != CRC_RESIDUE);
    assign len_bad = (cnt_q < CNT_W'(MIN_LEN)) || (cnt_q > CNT_W'(MAX_LEN));

    eth_crc32 u_crc (
        .c    (c),
        .rst  (rst),
        .init (state_q == ST_IDLE),
        .en   (accept),
        .d    (d),
        .crc  (crc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        dl_d       = dl_q;
        mac_ok_d   = mac_ok_q;
        bc_ok_d    = bc_ok_q;
        od_d       = od_q;
        odv_d      = 1'b0;
        osof_d     = 1'b0;
        oeof_d     = 1'b0;
        ogood_d    = 1'b0;
        ocrc_err_d = 1'b0;
        olen_err_d = 1'b0;
        omac_hit_d = 1'b0;
        olen_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d    = CNT_W'(1);
                    fill_d   = 3'd1;
                    dl_d     = {dl_q[2:0], d};
                    mac_ok_d = (d == MAC[47:40]);
                    bc_ok_d  = (d == BCAST_MAC[47:40]);
                    state_d  = erx ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    dl_d  = {dl_q[2:0], d};
                    // a full line means the oldest byte is payload, never FCS
                    if (fill_q == 3'd4) begin
                        od_d   = dl_q[3];
                        odv_d  = 1'b1;
                        osof_d = (cnt_q == CNT_W'(4));
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                    if (cnt_q < CNT_W'(6)) begin
                        mac_ok_d = mac_ok_q && (d == mac_sh[47:40]);
                        bc_ok_d  = bc_ok_q && (d == BCAST_MAC[47:40]);
                    end
                end
                if (erx) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                oeof_d     = 1'b1;
                ocrc_err_d = crc_bad;
                olen_err_d = len_bad;
                ogood_d    = !crc_bad && !len_bad;
                omac_hit_d = (cnt_q >= CNT_W'(6)) && (mac_ok_q || bc_ok_q);
                olen_d     = (cnt_q < CNT_W'(4)) ? '0 : cnt_q - CNT_W'(4);
                state_d    = ST_IDLE;
                cnt_d      = '0;
                fill_d     = '0;
                dl_d       = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fill_q     <= '0;
            dl_q       <= '0;
            mac_ok_q   <= 1'b0;
            bc_ok_q    <= 1'b0;
            od_q       <= '0;
            odv_q      <= 1'b0;
            osof_q     <= 1'b0;
            oeof_q     <= 1'b0;
            ogood_q    <= 1'b0;
            ocrc_err_q <= 1'b0;
            olen_err_q <= 1'b0;
            omac_hit_q <= 1'b0;
            olen_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            dl_q       <= dl_d;
            mac_ok_q   <= mac_ok_d;
            bc_ok_q    <= bc_ok_d;
            od_q       <= od_d;
            odv_q      <= odv_d;
            osof_q     <= osof_d;
            oeof_q     <= oeof_d;
            ogood_q    <= ogood_d;
            ocrc_err_q <= ocrc_err_d;
            olen_err_q <= olen_err_d;
            omac_hit_q <= omac_hit_d;
            olen_q     <= olen_d;
        end
    end

    assign od       = od_q;
    assign odv      = odv_q;
    assign osof     = osof_q;
    assign oeof     = oeof_q;
    assign ogood    = ogood_q;
    assign ocrc_err = ocrc_err_q;
    assign olen_err = olen_err_q;
    assign omac_hit = omac_hit_q;
    assign olen     = olen_q;

endmodule
